memb_pair_writer: RTL and testbench

Write-side controller for the memory-to-memory transfer path. It accepts 8-bit words read from memory A, one at a time, over a valid/ready handshake. It adds each consecutive pair and writes the sum into the 4-word memory B. It drives memory B's address, data and write enable, and reports completion and arithmetic overflow to the top-level controller.

---
 rtl/memxfer_pkg.sv | 9 +
 rtl/memb_pair_writer_counterB.sv | 15 +
 rtl/memb_pair_writer.sv | 73 +++++++
 tb/tb_memb_pair_writer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/memxfer_pkg.sv
// Constants and FSM encoding shared by the memory-to-memory transfer path
// (memory A read side and memory B write side).
package memxfer_pkg;
  localparam int DATA_W   = 8;
  localparam int ADDR_B_W = 2;
  localparam int DEPTH_B  = 2**ADDR_B_W;

  typedef enum logic [2:0] {IDLE, FIRST, SECOND, WRITE, DONE} state_t;
endpackage

// File: rtl/memb_pair_writer_counterB.sv
// Memory B write address counter; the FSM never asks it to step past the last word.
module counterB #(
  parameter int ADDR_B_W = 2
) (
  input  logic                clock,
  input  logic                Reset,
  input  logic                IncB,
  input  logic                ClrB,
  output logic [ADDR_B_W-1:0] AddrB
);
  always_ff @(posedge clock) begin
    if (Reset || ClrB) AddrB <= '0;
    else if (IncB)     AddrB <= AddrB + 1'b1;
  end
endmodule

// File: rtl/memb_pair_writer.sv
// Accepts words from memory A, sums consecutive pairs and writes each sum to
// memory B; all outputs are registers or a Moore decode of the state.
module memb_pair_writer
  import memxfer_pkg::*;
#(
  parameter int DATA_W   = memxfer_pkg::DATA_W,
  parameter int ADDR_B_W = memxfer_pkg::ADDR_B_W,
  parameter int DEPTH_B  = 2**ADDR_B_W
) (
  input  logic                clock,
  input  logic                Reset,
  input  logic                Start,
  input  logic [DATA_W-1:0]   DataIn,
  input  logic                InValid,
  output logic                InReady,
  output logic [ADDR_B_W-1:0] AddrB,
  output logic [DATA_W-1:0]   DataOutB,
  output logic                WEB,
  output logic                Busy,
  output logic                Done,
  output logic                Overflow
);
  state_t            state;
  logic [DATA_W-1:0] hold;
  logic [DATA_W:0]   sum;
  logic              accept, start_ok, last;

  assign accept   = InValid && InReady;
  assign start_ok = Start && (state == IDLE || state == DONE);
  assign last     = (AddrB == ADDR_B_W'(DEPTH_B - 1));
  assign sum      = {1'b0, hold} + {1'b0, DataIn};

  counterB #(.ADDR_B_W(ADDR_B_W)) u_cnt (
    .clock (clock),
    .Reset (Reset),
    .IncB  (state == WRITE && !last),
    .ClrB  (start_ok),
    .AddrB (AddrB)
  );

  always_ff @(posedge clock) begin
    if (Reset) begin
      state    <= IDLE;
      hold     <= '0;
      DataOutB <= '0;
      Overflow <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: if (start_ok) begin
          state    <= FIRST;
          Overflow <= 1'b0;
        end
        FIRST: if (accept) begin
          hold  <= DataIn;
          state <= SECOND;
        end
        SECOND: if (accept) begin
          // carry out of the pair sum is the sticky overflow event
          DataOutB <= sum[DATA_W-1:0];
          if (sum[DATA_W]) Overflow <= 1'b1;
          state <= WRITE;
        end
        WRITE:   state <= last ? DONE : FIRST;
        default: state <= IDLE;
      endcase
    end
  end

  assign InReady = (state == FIRST) || (state == SECOND);
  assign WEB     = (state == WRITE);
  assign Busy    = (state != IDLE) && (state != DONE);
  assign Done    = (state == DONE);
endmodule

// File: tb/tb_memb_pair_writer.sv
// Directed bench for memb_pair_writer: expected memory B writes go into a
// queue as pairs are issued; a negedge monitor pops and compares on each WEB.
module tb_memb_pair_writer;
  typedef struct {
    logic [1:0] a;
    logic [7:0] d;
    logic       ov;
  } wr_t;

  logic       clock = 1'b0;
  logic       Reset, Start, InValid;
  logic [7:0] DataIn;
  logic       InReady, WEB, Busy, Done, Overflow;
  logic [1:0] AddrB;
  logic [7:0] DataOutB;

  int  checks = 0;
  int  errors = 0;
  wr_t exp_q[$];
  time ts;

  always #5 clock = ~clock;

  memb_pair_writer dut (
    .clock    (clock),
    .Reset    (Reset),
    .Start    (Start),
    .DataIn   (DataIn),
    .InValid  (InValid),
    .InReady  (InReady),
    .AddrB    (AddrB),
    .DataOutB (DataOutB),
    .WEB      (WEB),
    .Busy     (Busy),
    .Done     (Done),
    .Overflow (Overflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // scoreboard monitor
  always @(negedge clock) begin
    if (WEB === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %0h data %0h", AddrB, DataOutB);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("write_addr", 32'(AddrB), 32'(e.a));
        chk("write_data", 32'(DataOutB), 32'(e.d));
        chk("write_ovf", 32'(Overflow), 32'(e.ov));
      end
    end
  end

  task automatic push(input logic [1:0] a, input logic [7:0] d, input logic ov);
    wr_t e;
    e.a = a; e.d = d; e.ov = ov;
    exp_q.push_back(e);
  endtask

  // called at a negedge; returns at the negedge just after Start is sampled
  task automatic start_xfer();
    Start = 1'b1;
    @(posedge clock);
    ts = $time;
    @(negedge clock);
    Start = 1'b0;
  endtask

  // stall = cycles of InValid low while the block is ready; returns at the
  // negedge following the accepting edge
  task automatic send_word(input logic [7:0] w, input int stall);
    int n = 0;
    if (stall > 0) begin
      InValid = 1'b0;
      while (!InReady && n < 100) begin @(negedge clock); n++; end
      repeat (stall) @(negedge clock);
    end
    InValid = 1'b1;
    DataIn  = w;
    while (!InReady && n < 100) begin @(negedge clock); n++; end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL accept_timeout: word %0h never accepted", w);
    end
    @(negedge clock);
  endtask

  // cyc < 0 skips the latency check
  task automatic wait_done(input int cyc);
    int n = 0;
    while (!Done && n < 200) begin @(negedge clock); n++; end
    chk("done_reached", 32'(Done), 32'd1);
    if (cyc >= 0) chk("done_latency", 32'($time - ts), 32'(cyc * 10 + 5));
  endtask

  task automatic stream_1to8(input int stall);
    push(2'd0, 8'd3, 1'b0);
    push(2'd1, 8'd7, 1'b0);
    push(2'd2, 8'd11, 1'b0);
    push(2'd3, 8'd15, 1'b0);
    for (int i = 1; i <= 8; i++) send_word(8'(i), stall);
    InValid = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; InValid = 1'b0; DataIn = '0;
    repeat (3) @(negedge clock);
    chk("rst_addr", 32'(AddrB), 0);
    chk("rst_data", 32'(DataOutB), 0);
    chk("rst_web", 32'(WEB), 0);
    chk("rst_busy", 32'(Busy), 0);
    chk("rst_done", 32'(Done), 0);
    chk("rst_ovf", 32'(Overflow), 0);
    chk("rst_ready", 32'(InReady), 0);
    Reset = 1'b0;
    @(negedge clock);
    chk("idle_ready", 32'(InReady), 0);

    // full stream
    start_xfer();
    stream_1to8(0);
    wait_done(12);
    chk("full_ovf", 32'(Overflow), 0);
    chk("full_addr_hold", 32'(AddrB), 3);
    chk("full_data_hold", 32'(DataOutB), 15);
    chk("full_busy", 32'(Busy), 0);
    chk("full_ready", 32'(InReady), 0);

    // overflow wrap plus Start ignored in FIRST
    start_xfer();
    push(2'd0, 8'h10, 1'b1);
    push(2'd1, 8'h03, 1'b1);
    push(2'd2, 8'h00, 1'b1);
    push(2'd3, 8'h80, 1'b1);
    send_word(8'hF0, 0);
    send_word(8'h20, 0);
    InValid = 1'b0;
    @(negedge clock);
    Start = 1'b1;
    @(negedge clock);
    Start = 1'b0;
    chk("first_start_addr", 32'(AddrB), 1);
    chk("first_start_ready", 32'(InReady), 1);
    chk("first_start_ovf", 32'(Overflow), 1);
    send_word(8'h01, 0);
    send_word(8'h02, 0);
    send_word(8'h80, 0);
    send_word(8'h80, 0);
    send_word(8'h7F, 0);
    send_word(8'h01, 0);
    InValid = 1'b0;
    wait_done(-1);
    chk("ovf_sticky_done", 32'(Overflow), 1);
    chk("ovf_data_hold", 32'(DataOutB), 8'h80);

    // restart from DONE, then stalled stream
    start_xfer();
    chk("restart_addr", 32'(AddrB), 0);
    chk("restart_done", 32'(Done), 0);
    chk("restart_ovf", 32'(Overflow), 0);
    chk("restart_ready", 32'(InReady), 1);
    stream_1to8(3);
    wait_done(36);

    // reset in SECOND of the second pair
    start_xfer();
    push(2'd0, 8'd11, 1'b0);
    send_word(8'd5, 0);
    send_word(8'd6, 0);
    send_word(8'd9, 0);
    InValid = 1'b0;
    chk("mid_ready", 32'(InReady), 1);
    chk("mid_addr", 32'(AddrB), 1);
    Reset = 1'b1;
    @(negedge clock);
    chk("mid_rst_addr", 32'(AddrB), 0);
    chk("mid_rst_web", 32'(WEB), 0);
    chk("mid_rst_busy", 32'(Busy), 0);
    chk("mid_rst_ready", 32'(InReady), 0);
    chk("mid_rst_data", 32'(DataOutB), 0);
    Reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("idle_no_write", 32'(WEB), 0);
    start_xfer();
    stream_1to8(0);
    wait_done(12);

    repeat (3) @(negedge clock);
    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
